ws2812b_pixel_receiver: RTL and testbench

Decodes a WS2812B single-wire NRZ stream. It is the receiving end of the stream produced by our LED ring driver, and it emulates one pixel.
- Captures the first 24-bit GRB word of each frame.
- Forwards all later bits on dout, as a real pixel does in a daisy chain.
- On a reset gap, latches the captured word to its display register.
- Used as an on-chip loopback checker for the ring driver, and as a chainable pixel model in system benches.

---
 rtl/ws2812b_pixel_receiver.sv | 116 +++++++++++
 tb/tb_ws2812b_pixel_receiver.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812b_pixel_receiver.sv
// WS2812B single-pixel receiver: decodes the NRZ stream, captures the first GRB word of each
// frame, forwards later bits on dout, and moves the captured word to the display on a reset gap.
module ws2812b_pixel_receiver #(
  parameter int THRESH_CYCLES   = 6,
  parameter int MIN_HIGH_CYCLES = 2,
  parameter int RESET_CYCLES    = 500,
  parameter int CNT_W           = 10
) (
  input  logic        clk,
  input  logic        res_n,
  input  logic        din,
  output logic        dout,
  output logic [23:0] pixel_grb,
  output logic        pixel_valid,
  output logic [23:0] display_grb,
  output logic        latch,
  output logic        short_frame
);

  typedef enum logic {CAPTURE = 1'b0, PASS = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] THRESH   = CNT_W'(THRESH_CYCLES);
  localparam logic [CNT_W-1:0] MIN_HIGH = CNT_W'(MIN_HIGH_CYCLES);
  localparam logic [CNT_W-1:0] RESET_M1 = CNT_W'(RESET_CYCLES - 1);

  logic             sync1_q, din_s_q, din_d_q;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0] low_cnt_q, low_cnt_d;
  state_t           state_q;
  logic [22:0]      shreg_q;
  logic [4:0]       bit_cnt_q;
  logic             dout_q, pixel_valid_q, latch_q, short_frame_q;
  logic [23:0]      pixel_q, display_q;

  logic rise, fall, bit_evt, bit_val, gap_evt;

  assign rise    = din_s_q & ~din_d_q;
  assign fall    = ~din_s_q & din_d_q;
  assign bit_evt = fall && (high_cnt_q >= MIN_HIGH);
  assign bit_val = (high_cnt_q >= THRESH);
  // Fires once per low stretch: the cycle low_cnt steps onto RESET_CYCLES.
  assign gap_evt = ~din_s_q && (low_cnt_q == RESET_M1);

  always_comb begin
    high_cnt_d = high_cnt_q;
    low_cnt_d  = low_cnt_q;
    if (rise) begin
      high_cnt_d = CNT_ONE;
      low_cnt_d  = '0;
    end else if (din_s_q) begin
      if (high_cnt_q != CNT_MAX) high_cnt_d = high_cnt_q + CNT_ONE;
    end else begin
      if (low_cnt_q != CNT_MAX) low_cnt_d = low_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      sync1_q    <= 1'b0;
      din_s_q    <= 1'b0;
      din_d_q    <= 1'b0;
      high_cnt_q <= '0;
      low_cnt_q  <= '0;
    end else begin
      sync1_q    <= din;
      din_s_q    <= sync1_q;
      din_d_q    <= din_s_q;
      high_cnt_q <= high_cnt_d;
      low_cnt_q  <= low_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q       <= CAPTURE;
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      dout_q        <= 1'b0;
      pixel_valid_q <= 1'b0;
      latch_q       <= 1'b0;
      short_frame_q <= 1'b0;
      pixel_q       <= '0;
      display_q     <= '0;
    end else begin
      pixel_valid_q <= 1'b0;
      latch_q       <= 1'b0;
      short_frame_q <= 1'b0;
      dout_q        <= (state_q == PASS) ? din_s_q : 1'b0;
      if (gap_evt) begin
        latch_q <= 1'b1;
        if (bit_cnt_q == 5'd24) display_q <= pixel_q;
        else if (bit_cnt_q != 5'd0) short_frame_q <= 1'b1;
        bit_cnt_q <= '0;
        state_q   <= CAPTURE;
      end else if ((state_q == CAPTURE) && bit_evt) begin
        shreg_q   <= {shreg_q[21:0], bit_val};
        bit_cnt_q <= bit_cnt_q + 5'd1;
        if (bit_cnt_q == 5'd23) begin
          pixel_q       <= {shreg_q, bit_val};
          pixel_valid_q <= 1'b1;
          state_q       <= PASS;
        end
      end
    end
  end

  assign dout        = dout_q;
  assign pixel_grb   = pixel_q;
  assign pixel_valid = pixel_valid_q;
  assign display_grb = display_q;
  assign latch       = latch_q;
  assign short_frame = short_frame_q;

endmodule

// File: tb/tb_ws2812b_pixel_receiver.sv
// Bench for ws2812b_pixel_receiver: a table of directed frames, hand-written corner sequences,
// and randomized frames checked against a frame-level model of the pixel.
module tb_ws2812b_pixel_receiver;
  localparam int THRESH = 6;
  localparam int MINH   = 2;
  localparam int RESETC = 500;

  logic        clk = 1'b0;
  logic        res_n = 1'b0;
  logic        din = 1'b0;
  logic        dout, pixel_valid, latch, short_frame;
  logic [23:0] pixel_grb, display_grb;

  ws2812b_pixel_receiver #(
    .THRESH_CYCLES(THRESH), .MIN_HIGH_CYCLES(MINH), .RESET_CYCLES(RESETC), .CNT_W(10)
  ) dut (
    .clk(clk), .res_n(res_n), .din(din), .dout(dout),
    .pixel_grb(pixel_grb), .pixel_valid(pixel_valid), .display_grb(display_grb),
    .latch(latch), .short_frame(short_frame)
  );

  always #5 clk = ~clk;

  // Cycle counter, input history (sampled at the active edge) and output monitor (opposite edge).
  int   cyc = 0;
  logic din_hist  [4096];
  logic dout_hist [4096];
  int   n_valid = 0, n_latch = 0, n_short = 0, n_dout1 = 0;
  int   last_valid_cyc = -1, last_latch_cyc = -1;
  logic [23:0] disp_after_latch = '0;
  logic latch_prev = 1'b0;

  always @(posedge clk) begin
    din_hist[cyc % 4096] <= din;
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    dout_hist[cyc % 4096] <= dout;
    if (pixel_valid) begin n_valid <= n_valid + 1; last_valid_cyc <= cyc; end
    if (latch)       begin n_latch <= n_latch + 1; last_latch_cyc <= cyc; end
    if (short_frame) n_short <= n_short + 1;
    if (dout)        n_dout1 <= n_dout1 + 1;
    if (latch_prev)  disp_after_latch <= display_grb;
    latch_prev <= latch;
  end

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    din = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int h, input int l);
    hold(1'b1, h);
    hold(1'b0, l);
  endtask

  task automatic send_bits(input logic [23:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      if (w[23-i]) pulse(8, 4);
      else         pulse(4, 8);
    end
  endtask

  // Frame-level model: bits decoded by pulse length, first 24 captured, rest forwarded.
  int          m_bits = 0, m_valid = 0, m_latch = 0, m_short = 0, m_dout1 = 0;
  logic [23:0] m_word = '0, m_pix = '0, m_disp = '0;

  task automatic m_gap();
    m_latch++;
    if (m_bits == 24) m_disp = m_pix;
    else if (m_bits > 0) m_short++;
    m_bits = 0;
  endtask

  task automatic m_pulse(input int h, input int l);
    pulse(h, l);
    if (m_bits == 24) m_dout1 += h;
    else if (h >= MINH) begin
      m_word = {m_word[22:0], (h >= THRESH)};
      m_bits++;
      if (m_bits == 24) begin
        m_pix = m_word;
        m_valid++;
      end
    end
    if (l >= RESETC) m_gap();
  endtask

  typedef struct {
    logic [23:0] w1;
    int          n1;
    logic [23:0] w2;
    int          n2;
    logic [23:0] exp_pix;
    logic [23:0] exp_disp;
    int          exp_valid;
    int          exp_latch;
    int          exp_short;
    int          exp_dout1;
  } vec_t;

  vec_t vecs [4];

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: cycle budget expired");
    $fatal(1, "cycle budget expired");
  end

  initial begin
    int b_valid, b_latch, b_short, b_dout1;
    int ws1, ws2, we, t0, wave_bad, quiet_bad;
    int nb, h, l, r;
    logic bv;

    vecs[0] = '{24'h00FF00, 24, 24'h000000, 0,  24'h00FF00, 24'h00FF00, 1, 1, 0, 0};
    vecs[1] = '{24'hA5C3F0, 24, 24'h123456, 24, 24'hA5C3F0, 24'hA5C3F0, 1, 1, 0, 132};
    vecs[2] = '{24'hABC000, 12, 24'h000000, 0,  24'hA5C3F0, 24'hA5C3F0, 0, 1, 1, 0};
    vecs[3] = '{24'h0000FF, 24, 24'h000000, 0,  24'h0000FF, 24'h0000FF, 1, 1, 0, 0};

    // Reset state, then an idle gap after release.
    repeat (4) @(negedge clk);
    check("rst_pixel", pixel_grb, 0);
    check("rst_display", display_grb, 0);
    check("rst_flags", {dout, pixel_valid, latch, short_frame}, 0);
    res_n = 1'b1;
    hold(1'b0, 600);
    check("idle_latch", n_latch, 1);
    check("idle_short", n_short, 0);
    check("idle_display", display_grb, 0);

    // Directed frames.
    for (int i = 0; i < 4; i++) begin
      b_valid = n_valid; b_latch = n_latch; b_short = n_short; b_dout1 = n_dout1;
      ws1 = cyc;
      send_bits(vecs[i].w1, vecs[i].n1);
      ws2 = cyc;
      send_bits(vecs[i].w2, vecs[i].n2);
      we = cyc;
      hold(1'b0, 600);
      check($sformatf("v%0d_pixel", i), pixel_grb, vecs[i].exp_pix);
      check($sformatf("v%0d_display", i), display_grb, vecs[i].exp_disp);
      check($sformatf("v%0d_valid", i), n_valid - b_valid, vecs[i].exp_valid);
      check($sformatf("v%0d_latch", i), n_latch - b_latch, vecs[i].exp_latch);
      check($sformatf("v%0d_short", i), n_short - b_short, vecs[i].exp_short);
      check($sformatf("v%0d_dout_ones", i), n_dout1 - b_dout1, vecs[i].exp_dout1);
      if (vecs[i].exp_latch > 0)
        check($sformatf("v%0d_disp_at_latch", i), disp_after_latch, vecs[i].exp_disp);
      if (vecs[i].n2 > 0) begin
        quiet_bad = 0;
        wave_bad  = 0;
        for (int k = ws1 + 3; k < ws2 + 3; k++)
          if (dout_hist[k % 4096] !== 1'b0) quiet_bad++;
        for (int k = ws2; k < we; k++)
          if (dout_hist[(k + 3) % 4096] !== din_hist[k % 4096]) wave_bad++;
        check($sformatf("v%0d_dout_quiet", i), quiet_bad, 0);
        check($sformatf("v%0d_dout_replay", i), wave_bad, 0);
      end
    end

    // Glitches between bits are ignored in capture; the one after the last bit is forwarded.
    b_dout1 = n_dout1;
    for (int i = 0; i < 24; i++) begin
      send_bits((24'h800001 << i), 1);
      pulse(1, 3);
    end
    hold(1'b0, 600);
    check("glitch_pixel", pixel_grb, 24'h800001);
    check("glitch_display", display_grb, 24'h800001);
    check("glitch_forwarded", n_dout1 - b_dout1, 1);

    // Threshold boundary: 6 -> 1, 5 -> 0, 2 (minimum) -> 0, then 21 ones.
    pulse(6, 6);
    pulse(5, 7);
    pulse(2, 10);
    send_bits(24'hFFFFFF, 21);
    hold(1'b0, 600);
    check("thresh_pixel", pixel_grb, 24'h9FFFFF);

    // High held past counter saturation decodes as 1.
    pulse(1100, 4);
    send_bits(24'h000000, 23);
    hold(1'b0, 600);
    check("sat_pixel", pixel_grb, 24'h800000);

    // 499-cycle low mid-frame does not latch; an exact 500-cycle low does, once.
    b_latch = n_latch; b_short = n_short; b_valid = n_valid;
    send_bits(24'h5A5A5A, 11);
    pulse(8, 499);
    send_bits(24'h5A5A5A << 12, 11);
    hold(1'b1, 4);
    t0 = cyc;
    hold(1'b0, 2000);
    check("gap_pixel", pixel_grb, 24'h5A5A5A);
    check("gap_valid", n_valid - b_valid, 1);
    check("gap_latch_count", n_latch - b_latch, 1);
    check("gap_short", n_short - b_short, 0);
    check("valid_latency", last_valid_cyc - t0, 3);
    check("latch_latency", last_latch_cyc - t0, RESETC + 2);
    check("gap_display", display_grb, 24'h5A5A5A);

    // Reset mid-frame clears everything at once; next frame is captured intact.
    b_latch = n_latch; b_short = n_short;
    send_bits(24'hFFFFFF, 10);
    res_n = 1'b0;
    #1;
    check("midrst_pixel", pixel_grb, 0);
    check("midrst_display", display_grb, 0);
    check("midrst_flags", {dout, pixel_valid, latch, short_frame}, 0);
    @(negedge clk);
    hold(1'b0, 4);
    res_n = 1'b1;
    send_bits(24'h010203, 24);
    hold(1'b0, 600);
    check("postrst_pixel", pixel_grb, 24'h010203);
    check("postrst_display", display_grb, 24'h010203);
    check("postrst_latch", n_latch - b_latch, 1);
    check("postrst_short", n_short - b_short, 0);

    // Randomized frames against the model.
    m_pix  = 24'h010203;
    m_disp = 24'h010203;
    m_bits = 0;
    b_valid = n_valid; b_latch = n_latch; b_short = n_short; b_dout1 = n_dout1;
    for (int f = 0; f < 20; f++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      nb = 24;
      else if (r < 8) nb = $urandom_range(1, 23);
      else            nb = $urandom_range(25, 32);
      for (int b = 0; b < nb; b++) begin
        if ($urandom_range(0, 7) == 0) m_pulse(1, $urandom_range(3, 6));
        bv = 1'($urandom_range(0, 1));
        h  = bv ? $urandom_range(THRESH, 12) : $urandom_range(MINH, THRESH - 1);
        l  = $urandom_range(3, 8);
        m_pulse(h, l);
      end
      if ($urandom_range(0, 3) == 0) begin
        hold(1'b0, $urandom_range(20, 300));
      end else begin
        hold(1'b0, $urandom_range(520, 700));
        m_gap();
      end
      check($sformatf("rnd%0d_pixel", f), pixel_grb, m_pix);
      check($sformatf("rnd%0d_display", f), display_grb, m_disp);
      check($sformatf("rnd%0d_valid", f), n_valid - b_valid, m_valid);
      check($sformatf("rnd%0d_latch", f), n_latch - b_latch, m_latch);
      check($sformatf("rnd%0d_short", f), n_short - b_short, m_short);
      check($sformatf("rnd%0d_dout_ones", f), n_dout1 - b_dout1, m_dout1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
